tape_capture: RTL

Cassette record path for the CoCo2 core. Sits downstream of the `po8` machine core. It samples the cassette output bit while the motor relay is on and decodes 1200/2400 Hz FSK cycles into bits. It assembles the bits into bytes and writes them sequentially into SDRAM through a small FIFO, so the HPS can save the recording as a CAS image.

---
 rtl/coco2_pkg.sv | 23 ++
 rtl/tape_fifo.sv | 66 ++++++
 rtl/tape_capture.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/coco2_pkg.sv
// coco2_pkg: constants and types shared by the CoCo2 cassette blocks
// (record path tape_capture and the playback cassette block).
//   Q_HZ            6809 Q tick rate the period thresholds are expressed in
//   tape_state_t    SDRAM write FSM states
//   period_t        11-bit period measured in Q ticks
//   *_DEF           default FSK period thresholds
package coco2_pkg;

    localparam int unsigned Q_HZ = 894886;

    typedef enum logic {
        IDLE,
        WAIT
    } tape_state_t;

    typedef logic [10:0] period_t;

    localparam period_t PERIOD_SAT  = 11'h7FF;
    localparam period_t THRESH_DEF  = 11'd560;
    localparam period_t MIN_PER_DEF = 11'd100;
    localparam period_t MAX_PER_DEF = 11'd1500;

endpackage

// File: rtl/tape_fifo.sv
// tape_fifo: synchronous byte FIFO with registered read port.
//   clk, reset (sync, active-low), flush (sync clear of pointers/count)
//   push/din   write side; a push while full is accepted only with a pop
//   pop/dout   read side; dout updates on the clock after pop
//   full, empty, count   occupancy status
module tape_fifo #(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        do_wr = push & (~full | pop) & ~flush;
        do_rd = pop & ~empty & ~flush;
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tape_capture.sv
// tape_capture: cassette record path. Decodes 1200/2400 Hz FSK from the
// cassette output bit while the motor relay is on, assembles LSB-first
// bytes and writes them sequentially to SDRAM through tape_fifo.
//   clk, reset (sync, active-low), q_en (Q-rate tick)
//   cas_in (async level), en (motor relay), rec_clear (restart pulse)
//   sdram_addr/sdram_din/sdram_we/sdram_ack   write handshake
//   byte_count, overflow (sticky), busy
// Optional: define TAPE_CAPTURE_DEBUG_EN to add dbg_period / dbg_bits.
module tape_capture
    import coco2_pkg::*;
#(
    parameter logic [24:0] BASE_ADDR  = 25'h0100000,
    parameter logic [24:0] LIMIT      = 25'h0200000,
    parameter period_t     THRESH     = THRESH_DEF,
    parameter period_t     MIN_PER    = MIN_PER_DEF,
    parameter period_t     MAX_PER    = MAX_PER_DEF,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        q_en,
    input  logic        cas_in,
    input  logic        en,
    input  logic        rec_clear,
    output logic [24:0] sdram_addr,
    output logic [7:0]  sdram_din,
    output logic        sdram_we,
    input  logic        sdram_ack,
    output logic [24:0] byte_count,
    output logic        overflow,
`ifdef TAPE_CAPTURE_DEBUG_EN
    output logic [10:0] dbg_period,
    output logic [2:0]  dbg_bits,
`endif
    output logic        busy
);

    localparam int unsigned FAW = $clog2(FIFO_DEPTH);

    logic        cas_s1, cas_s2, cas_s3;
    logic        rise;
    period_t     per_cnt;
    logic        armed;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;

    logic        edge_arm, edge_gap, edge_bit;
    logic        bit_val, byte_done;
    logic [7:0]  new_byte;

    logic        fifo_push, fifo_pop, fifo_flush;
    logic        fifo_full, fifo_empty;
    logic [FAW:0] fifo_count;
    logic        drop;

    tape_state_t state, next_state;
    logic        ack_take;

    assign rise = cas_s2 & ~cas_s3;

    // Edge classification; glitch edges fall through all three and are ignored.
    always_comb begin
        edge_arm  = en & rise & ~armed;
        edge_gap  = en & rise & armed & (per_cnt >= MAX_PER);
        edge_bit  = en & rise & armed & (per_cnt >= MIN_PER) & (per_cnt < MAX_PER);
        bit_val   = (per_cnt < THRESH);
        byte_done = edge_bit & (bit_cnt == 3'd7);
        new_byte  = {bit_val, shreg[7:1]};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cas_s1  <= 1'b0;
            cas_s2  <= 1'b0;
            cas_s3  <= 1'b0;
            per_cnt <= '0;
            armed   <= 1'b0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            cas_s1 <= cas_in;
            cas_s2 <= cas_s1;
            cas_s3 <= cas_s2;
            if (!en) begin
                per_cnt <= '0;
                armed   <= 1'b0;
                bit_cnt <= '0;
            end else begin
                if (edge_arm | edge_gap | edge_bit)
                    per_cnt <= '0;
                else if (q_en && per_cnt != PERIOD_SAT)
                    per_cnt <= per_cnt + 11'd1;
                if (edge_arm)
                    armed <= 1'b1;
                if (edge_gap)
                    bit_cnt <= '0;
                else if (edge_bit) begin
                    shreg   <= new_byte;
                    bit_cnt <= bit_cnt + 3'd1;   // wraps to 0 on the 8th bit
                end
            end
            if (rec_clear)
                bit_cnt <= '0;
        end
    end

`ifdef TAPE_CAPTURE_DEBUG_EN
    always_ff @(posedge clk) begin
        if (!reset)
            dbg_period <= '0;
        else if (edge_bit)
            dbg_period <= per_cnt;
    end
    assign dbg_bits = bit_cnt;
`endif

    // While overflow is set the FIFO is held flushed, so captured bytes are discarded.
    always_comb begin
        fifo_flush = rec_clear | overflow;
        fifo_push  = byte_done & ~overflow & ~rec_clear;
        drop       = fifo_push & fifo_full & ~fifo_pop;
    end

    tape_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .din   (new_byte),
        .pop   (fifo_pop),
        .dout  (sdram_din),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        next_state = state;
        fifo_pop   = 1'b0;
        ack_take   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !overflow) begin
                    fifo_pop   = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (sdram_ack) begin
                    ack_take   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (rec_clear) begin
            fifo_pop   = 1'b0;
            ack_take   = 1'b0;
            next_state = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Data comes straight from the FIFO read register, which only changes on a pop (IDLE only).
    assign sdram_we = (state == WAIT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            sdram_addr <= BASE_ADDR;
            byte_count <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else if (rec_clear) begin
            sdram_addr <= BASE_ADDR;
            byte_count <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (ack_take) begin
                sdram_addr <= sdram_addr + 25'd1;
                byte_count <= byte_count + 25'd1;
                if (sdram_addr + 25'd1 == LIMIT)
                    overflow <= 1'b1;
            end
            if (drop)
                overflow <= 1'b1;
            busy <= (fifo_count != '0) | (state == WAIT);
        end
    end

endmodule
